spram_access_ctrl: RTL and testbench

//  Initiator side of the single-port block RAM interface (clk/we/addr/data/out). Arbitrates a write

---
 rtl/spram_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_spram_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram_access_ctrl
// Description : Initiator side of a single-port block RAM. Arbitrates a
//               write client, a read client and a built-in clear engine onto
//               the one RAM port. Tracks the RAM's 1-cycle read latency and
//               returns registered read data with a one-cycle valid pulse.
// Ports       : clk_i, resetn_i          clock / async active-low reset
//               wr_valid_i/wr_ready_o    write handshake, wr_addr_i, wr_data_i
//               rd_valid_i/rd_ready_o    read handshake, rd_addr_i
//               rd_rvalid_o, rd_rdata_o  read response (registered)
//               clr_start_i              pulse: start a clear sweep
//               clr_busy_o, clr_done_o   sweep status (registered)
//               ram_we_o/addr_o/data_o   drive to RAM, ram_out_i from RAM
// Revision    : 1.0 - initial release
// ============================================================================
module spram_access_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_rvalid_o,
    output logic [DATA_WIDTH-1:0] rd_rdata_o,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_out_i
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]          state_q, state_d;
    // One extra bit so the terminal count is seen as a carry, not a wrap to 0.
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH:0] cnt_inc;
    logic                clr_last;
    logic                rd_pend_q;
    logic                rd_rvalid_q;
    logic [DATA_WIDTH-1:0] rd_rdata_q;
    logic                clr_busy_q;
    logic                clr_done_q;
    logic                rd_accept;

    assign cnt_inc  = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign clr_last = (state_q == S_CLEAR) && cnt_inc[ADDR_WIDTH];

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_inc;
                if (clr_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Handshakes are gated by resetn_i so nothing is accepted, and the RAM is
    // never written, while reset is held.
    always_comb begin
        wr_ready_o = 1'b0;
        rd_ready_o = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        case (state_q)
            S_IDLE: begin
                wr_ready_o = resetn_i && !clr_start_i;
                rd_ready_o = resetn_i && !clr_start_i && !wr_valid_i;
                if (wr_valid_i && wr_ready_o) begin
                    ram_we_o   = 1'b1;
                    ram_addr_o = wr_addr_i;
                    ram_data_o = wr_data_i;
                end else if (rd_valid_i && rd_ready_o) begin
                    ram_addr_o = rd_addr_i;
                end
            end
            S_CLEAR: begin
                ram_we_o   = 1'b1;
                ram_addr_o = cnt_q[ADDR_WIDTH-1:0];
                ram_data_o = FILL_VALUE;
            end
            default: begin
                ram_we_o = 1'b0;
            end
        endcase
    end

    assign rd_accept = rd_valid_i && rd_ready_o;

    // ---------------- read return path and sweep status ----------------
    // rd_pend_q marks the cycle in which ram_out_i carries an accepted read;
    // the data is captured one edge later so the response is fully registered.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_pend_q   <= 1'b0;
            rd_rvalid_q <= 1'b0;
            rd_rdata_q  <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            rd_pend_q   <= rd_accept;
            rd_rvalid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_rdata_q <= ram_out_i;
            end
            clr_busy_q  <= (state_d == S_CLEAR);
            clr_done_q  <= clr_last;
        end
    end

    assign rd_rvalid_o = rd_rvalid_q;
    assign rd_rdata_o  = rd_rdata_q;
    assign clr_busy_o  = clr_busy_q;
    assign clr_done_o  = clr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_access_ctrl
// Description : Directed self-checking bench for spram_access_ctrl with a
//               behavioural 16x8 single-port RAM attached to the RAM port.
//               Inputs change on the falling edge; outputs are checked 1 ns
//               after the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_access_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid, rd_valid, clr_start;
    logic       wr_ready, rd_ready, rd_rvalid, clr_busy, clr_done, ram_we;
    logic [3:0] wr_addr, rd_addr, ram_addr;
    logic [7:0] wr_data, rd_rdata, ram_data, ram_out;
    logic [7:0] mem [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spram_access_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FILL_VALUE(8'h00)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
        .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
        .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_out_i(ram_out)
    );

    // Behavioural single-port RAM: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_out <= mem[ram_addr];
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; rd_valid = 1'b0; clr_start = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Issue one read and check the response two cycles after the handshake.
    task automatic read_expect(input logic [3:0] a, input logic [7:0] exp, input string nm);
        rd_valid = 1'b1; rd_addr = a;
        #0;
        tests++;
        if (rd_ready !== 1'b1) begin fails++; $display("FAIL %s rd_ready got %b want 1", nm, rd_ready); end
        tick();
        rd_valid = 1'b0;
        tests++;
        if (rd_rvalid !== 1'b0) begin fails++; $display("FAIL %s early rd_rvalid got %b want 0", nm, rd_rvalid); end
        tick();
        tests++;
        if (rd_rvalid !== 1'b1 || rd_rdata !== exp) begin
            fails++; $display("FAIL %s rvalid/rdata got %b/%h want 1/%h", nm, rd_rvalid, rd_rdata, exp);
        end
        tick();
        tests++;
        if (rd_rvalid !== 1'b0) begin fails++; $display("FAIL %s rvalid pulse width got %b want 0", nm, rd_rvalid); end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 4'd1; wr_data = 8'hFF;
        tick();
        tests++;
        if ({wr_ready, rd_ready, ram_we} !== 3'b000) begin
            fails++; $display("FAIL reset_handshake wr/rd/we got %b want 000", {wr_ready, rd_ready, ram_we});
        end
        tests++;
        if ({rd_rvalid, clr_busy, clr_done} !== 3'b000 || rd_rdata !== 8'h00) begin
            fails++; $display("FAIL reset_regs rvalid/busy/done/rdata got %b%b%b/%h want 000/00",
                              rd_rvalid, clr_busy, clr_done, rd_rdata);
        end
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        tests++;
        if (wr_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd0) begin
            fails++; $display("FAIL reset_release wr_ready/we/addr got %b/%b/%h want 1/0/0", wr_ready, ram_we, ram_addr);
        end
    endtask

    task automatic test_write_read();
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        #0;
        tests++;
        if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd3 || ram_data !== 8'hA5) begin
            fails++; $display("FAIL wr_drive ready/we/addr/data got %b/%b/%h/%h want 1/1/3/a5",
                              wr_ready, ram_we, ram_addr, ram_data);
        end
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'd3;
        #0;
        tests++;
        if (ram_we !== 1'b0 || ram_addr !== 4'd3) begin
            fails++; $display("FAIL rd_drive we/addr got %b/%h want 0/3", ram_we, ram_addr);
        end
        rd_valid = 1'b0;
        read_expect(4'd3, 8'hA5, "write_read");
    endtask

    task automatic test_priority();
        do_write(4'd6, 8'h66);
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
        rd_valid = 1'b1; rd_addr = 4'd6;
        #0;
        tests++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 4'd5) begin
            fails++; $display("FAIL prio_wr wr_ready/rd_ready/we/addr got %b/%b/%b/%h want 1/0/1/5",
                              wr_ready, rd_ready, ram_we, ram_addr);
        end
        tick();
        wr_valid = 1'b0;
        read_expect(4'd6, 8'h66, "prio_rd");
        read_expect(4'd5, 8'h55, "prio_wr_data");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_write(4'(i), 8'h10 + 8'(i));
        for (int j = 0; j < 7; j++) begin
            if (j < 4) begin
                rd_valid = 1'b1; rd_addr = 4'(j);
                #0;
                tests++;
                if (rd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b want 1", j, rd_ready); end
            end else begin
                rd_valid = 1'b0;
            end
            tests++;
            if (j >= 2 && j < 6) begin
                if (rd_rvalid !== 1'b1 || rd_rdata !== 8'h10 + 8'(j - 2)) begin
                    fails++; $display("FAIL b2b_data[%0d] rvalid/rdata got %b/%h want 1/%h",
                                      j, rd_rvalid, rd_rdata, 8'h10 + 8'(j - 2));
                end
            end else if (rd_rvalid !== 1'b0) begin
                fails++; $display("FAIL b2b_gap[%0d] rvalid got %b want 0", j, rd_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_read_then_clear();
        rd_valid = 1'b1; rd_addr = 4'd2;
        tick();
        rd_valid = 1'b0; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tests++;
        if (rd_rvalid !== 1'b1 || rd_rdata !== 8'h12 || clr_busy !== 1'b1) begin
            fails++; $display("FAIL rd_then_clr rvalid/rdata/busy got %b/%h/%b want 1/12/1", rd_rvalid, rd_rdata, clr_busy);
        end
        for (int i = 0; i < 16; i++) tick();
        tests++;
        if (clr_done !== 1'b1) begin fails++; $display("FAIL rd_then_clr_done got %b want 1", clr_done); end
        tick();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'h30 + 8'(i));
        clr_start = 1'b1;
        #0;
        tests++;
        if (wr_ready !== 1'b0 || rd_ready !== 1'b0 || clr_busy !== 1'b0) begin
            fails++; $display("FAIL clr_start_cycle wr/rd/busy got %b/%b/%b want 0/0/0", wr_ready, rd_ready, clr_busy);
        end
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (clr_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'(i) || ram_data !== 8'h00 || clr_done !== 1'b0) begin
                fails++; $display("FAIL clr_sweep[%0d] busy/we/addr/data/done got %b/%b/%h/%h/%b want 1/1/%h/00/0",
                                  i, clr_busy, ram_we, ram_addr, ram_data, clr_done, 4'(i));
            end
            tick();
        end
        tests++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b1) begin
            fails++; $display("FAIL clr_done busy/done got %b/%b want 0/1", clr_busy, clr_done);
        end
        tick();
        tests++;
        if (clr_done !== 1'b0) begin fails++; $display("FAIL clr_done_pulse got %b want 0", clr_done); end
        read_expect(4'd0, 8'h00, "clr_rd0");
        read_expect(4'd7, 8'h00, "clr_rd7");
        read_expect(4'd15, 8'h00, "clr_rd15");
    endtask

    task automatic test_clear_hold();
        clr_start = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 8'h99;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            clr_start = (i == 5);
            #0;
            tests++;
            if (wr_ready !== 1'b0 || ram_addr !== 4'(i) || ram_data !== 8'h00) begin
                fails++; $display("FAIL clr_hold[%0d] wr_ready/addr/data got %b/%h/%h want 0/%h/00",
                                  i, wr_ready, ram_addr, ram_data, 4'(i));
            end
            tick();
        end
        clr_start = 1'b0;
        #0;
        tests++;
        if (clr_done !== 1'b1 || wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd9 || ram_data !== 8'h99) begin
            fails++; $display("FAIL clr_hold_wr done/wr_ready/we/addr/data got %b/%b/%b/%h/%h want 1/1/1/9/99",
                              clr_done, wr_ready, ram_we, ram_addr, ram_data);
        end
        tick();
        wr_valid = 1'b0;
        tests++;
        if (clr_busy !== 1'b0) begin fails++; $display("FAIL clr_hold_norestart busy got %b want 0", clr_busy); end
        read_expect(4'd9, 8'h99, "clr_hold_rd");
    endtask

    task automatic test_reset_mid_sweep();
        int bad_done = 0;
        do_write(4'd4, 8'h44);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (ram_addr !== 4'd7 || clr_busy !== 1'b1) begin
            fails++; $display("FAIL rst_mid_pre addr/busy got %h/%b want 7/1", ram_addr, clr_busy);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if (clr_busy !== 1'b0 || rd_rvalid !== 1'b0 || ram_we !== 1'b0) begin
            fails++; $display("FAIL rst_mid busy/rvalid/we got %b/%b/%b want 0/0/0", clr_busy, rd_rvalid, ram_we);
        end
        tick();
        resetn = 1'b1;
        tick();
        tests++;
        if (wr_ready !== 1'b1 || ram_we !== 1'b0 || clr_busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_idle wr_ready/we/busy got %b/%b/%b want 1/0/0", wr_ready, ram_we, clr_busy);
        end
        for (int i = 0; i < 20; i++) begin
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad_done++;
            tick();
        end
        tests++;
        if (bad_done != 0) begin fails++; $display("FAIL rst_mid_nodone cycles_with_done got %0d want 0", bad_done); end
        // A read in flight when reset hits must not produce a response.
        rd_valid = 1'b1; rd_addr = 4'd4;
        tick();
        rd_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        tests++;
        if (rd_rvalid !== 1'b0) begin fails++; $display("FAIL rst_drop_rd rvalid got %b want 0", rd_rvalid); end
        tick();
        tests++;
        if (rd_rvalid !== 1'b0) begin fails++; $display("FAIL rst_drop_rd2 rvalid got %b want 0", rd_rvalid); end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_write_read();
        test_priority();
        test_back_to_back();
        test_read_then_clear();
        test_clear();
        test_clear_hold();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
